// File: rtl/instr_encoder_loader_pkg.sv
// Shared ISA constants for the instruction encoder/loader.
//   type*  : 2-bit instruction class in word[8:7]
//   i*     : 4-bit sub-op for typeI
//   ii*    : 1-bit sub-op for typeII
//   iii*   : 2-bit sub-op for typeIII
//   iv*    : 1-bit sub-op for typeIV
//   o*     : 5-bit decoded operation codes presented on the input stream
// Also holds the loader state type and error-code values.
package instr_encoder_loader_pkg;

  localparam int ISA_IW = 9;

  localparam logic [1:0] typeI   = 2'b00;
  localparam logic [1:0] typeII  = 2'b01;
  localparam logic [1:0] typeIII = 2'b10;
  localparam logic [1:0] typeIV  = 2'b11;

  localparam logic [3:0] iADD   = 4'd0;
  localparam logic [3:0] iMOVER = 4'd1;
  localparam logic [3:0] iMOVEA = 4'd2;
  localparam logic [3:0] iRXOR  = 4'd3;
  localparam logic [3:0] iLUT   = 4'd4;
  localparam logic [3:0] iXOR   = 4'd5;
  localparam logic [3:0] iAND   = 4'd6;
  localparam logic [3:0] iLOAD  = 4'd7;
  localparam logic [3:0] iSTORE = 4'd8;
  localparam logic [3:0] iHALT  = 4'd9;

  localparam logic iiBEQ = 1'b0;
  localparam logic iiBLT = 1'b1;

  localparam logic [1:0] iiiANDI = 2'd0;
  localparam logic [1:0] iiiADDI = 2'd1;
  localparam logic [1:0] iiiSUB  = 2'd2;
  localparam logic [1:0] iiiJUMP = 2'd3;

  localparam logic ivLSR = 1'b0;
  localparam logic ivRSR = 1'b1;

  localparam logic [4:0] oADD   = 5'd0;
  localparam logic [4:0] oMOVER = 5'd1;
  localparam logic [4:0] oMOVEA = 5'd2;
  localparam logic [4:0] oRXOR  = 5'd3;
  localparam logic [4:0] oLUT   = 5'd4;
  localparam logic [4:0] oXOR   = 5'd5;
  localparam logic [4:0] oAND   = 5'd6;
  localparam logic [4:0] oLOAD  = 5'd7;
  localparam logic [4:0] oSTORE = 5'd8;
  localparam logic [4:0] oHALT  = 5'd9;
  localparam logic [4:0] oBEQ   = 5'd10;
  localparam logic [4:0] oBLT   = 5'd11;
  localparam logic [4:0] oANDI  = 5'd12;
  localparam logic [4:0] oADDI  = 5'd13;
  localparam logic [4:0] oSUB   = 5'd14;
  localparam logic [4:0] oJUMP  = 5'd15;
  localparam logic [4:0] oLSR   = 5'd16;
  localparam logic [4:0] oRSR   = 5'd17;

  typedef enum logic [1:0] {LD_IDLE, LD_RUN, LD_DONE, LD_ERROR} ld_state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OP   = 2'b01;
  localparam logic [1:0] ERR_IMM  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

endpackage

// File: rtl/instr_encoder_loader_field_encoder.sv
// Combinational field packer: decoded OP/register/immediate -> 9-bit word.
//   op       in  5  operation code (o*)
//   rg       in  3  register field
//   imm      in  5  immediate
//   word     out 9  packed machine word (0 when op is illegal)
//   legal_op out 1  op matches a defined o* code
//   imm_ok   out 1  immediate fits its field (only 3-bit fields are checked)
module instr_field_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [4:0] op,
  input  logic [2:0] rg,
  input  logic [4:0] imm,
  output logic [8:0] word,
  output logic       legal_op,
  output logic       imm_ok
);

  // typeII/typeIV only carry imm[2:0]; anything in imm[4:3] would be lost.
  logic imm3_fits;
  assign imm3_fits = (imm[4:3] == 2'b00);

  always_comb begin
    word     = '0;
    legal_op = 1'b1;
    imm_ok   = 1'b1;
    case (op)
      oADD:   word = {typeI, iADD,   rg};
      oMOVER: word = {typeI, iMOVER, rg};
      oMOVEA: word = {typeI, iMOVEA, rg};
      oRXOR:  word = {typeI, iRXOR,  rg};
      oLUT:   word = {typeI, iLUT,   rg};
      oXOR:   word = {typeI, iXOR,   rg};
      oAND:   word = {typeI, iAND,   rg};
      oLOAD:  word = {typeI, iLOAD,  rg};
      oSTORE: word = {typeI, iSTORE, rg};
      oHALT:  word = {typeI, iHALT,  rg};
      oBEQ:   begin word = {typeII, iiBEQ, rg, imm[2:0]}; imm_ok = imm3_fits; end
      oBLT:   begin word = {typeII, iiBLT, rg, imm[2:0]}; imm_ok = imm3_fits; end
      oANDI:  word = {typeIII, iiiANDI, imm};
      oADDI:  word = {typeIII, iiiADDI, imm};
      oSUB:   word = {typeIII, iiiSUB,  imm};
      oJUMP:  word = {typeIII, iiiJUMP, imm};
      oLSR:   begin word = {typeIV, ivLSR, rg, imm[2:0]}; imm_ok = imm3_fits; end
      oRSR:   begin word = {typeIV, ivRSR, rg, imm[2:0]}; imm_ok = imm3_fits; end
      default: legal_op = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: takes decoded fields over a valid/ready stream,
// packs them into machine words and writes them to sequential addresses.
//   clk, rst_n            clock, asynchronous active-low reset
//   start, start_addr     begin a load (ignored while a load is running)
//   in_valid/in_ready     field beat handshake; in_op/in_reg/in_imm fields
//   wr_en/wr_addr/wr_data registered instruction-memory write port
//   busy                  load running
//   done/err/err_code     level status of the last load
//   count                 words written in the current/last load
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int AW = 8,
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [2:0]    in_reg,
  input  logic [4:0]    in_imm,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   count
);

  // The word layout is fixed by the ISA; a different IW cannot be encoded.
  if (IW != ISA_IW) begin : g_iw_check
    $error("instr_encoder_loader: IW must be 9");
  end

  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  ld_state_t     state;
  logic [AW-1:0] ptr;
  logic [8:0]    enc_word;
  logic          legal_op;
  logic          imm_ok;
  logic          is_halt;

  logic          vld_p1;
  logic [AW-1:0] wr_addr_p1;
  logic [IW-1:0] wr_data_p1;

  instr_field_encoder u_enc (
    .op       (in_op),
    .rg       (in_reg),
    .imm      (in_imm),
    .word     (enc_word),
    .legal_op (legal_op),
    .imm_ok   (imm_ok)
  );

  assign is_halt  = (in_op == oHALT);
  assign in_ready = (state == LD_RUN);
  assign busy     = (state == LD_RUN);
  assign wr_en    = vld_p1;
  assign wr_addr  = wr_addr_p1;
  assign wr_data  = wr_data_p1;

  // ---- stage p0 -> p1: accept beat, encode, register write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LD_IDLE;
      ptr        <= '0;
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      count      <= '0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        LD_RUN: begin
          if (in_valid) begin
            if (!legal_op) begin
              state    <= LD_ERROR;
              err      <= 1'b1;
              err_code <= ERR_OP;
            end else if (!imm_ok) begin
              state    <= LD_ERROR;
              err      <= 1'b1;
              err_code <= ERR_IMM;
            end else begin
              vld_p1     <= 1'b1;
              wr_addr_p1 <= ptr;
              wr_data_p1 <= enc_word;
              count      <= count + CNT_ONE;
              // HALT wins over overflow; the pointer never wraps past the top.
              if (is_halt) begin
                state <= LD_DONE;
                done  <= 1'b1;
              end else if (ptr == PTR_LAST) begin
                state    <= LD_ERROR;
                err      <= 1'b1;
                err_code <= ERR_OVF;
              end else begin
                ptr <= ptr + PTR_ONE;
              end
            end
          end
        end
        default: begin
          if (start) begin
            state    <= LD_RUN;
            ptr      <= start_addr;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            count    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] start_addr;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_op;
  logic [2:0] in_reg;
  logic [4:0] in_imm;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [8:0] count;

  typedef struct packed {
    logic [7:0] a;
    logic [8:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  instr_encoder_loader #(.AW(8), .IW(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_reg     (in_reg),
    .in_imm     (in_imm),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%h data=%b required=no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          n_fail++;
          $display("FAIL write actual=%h/%b required=%h/%b", wr_addr, wr_data, e.a, e.d);
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] a);
    start = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic set_beat(input logic [4:0] op, input logic [2:0] rg, input logic [4:0] imm);
    in_valid = 1'b1;
    in_op = op;
    in_reg = rg;
    in_imm = imm;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    in_valid = 1'b0;
    in_op = '0;
    in_reg = '0;
    in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err, err_code, count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state actual=%b required=0",
               {in_ready, wr_en, wr_addr, wr_data, busy, done, err, err_code, count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_write;
    do_start(8'h10);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_run ready=%b busy=%b required=1/1", in_ready, busy);
    end
    set_beat(oADDI, 3'd0, 5'd7);
    exp_q.push_back('{a: 8'h10, d: 9'b10_01_00111});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (wr_en !== 1'b1 || wr_addr !== 8'h10 || wr_data !== 9'b10_01_00111 || count !== 9'd1) begin
      n_fail++;
      $display("FAIL addi_latency en=%b addr=%h data=%b cnt=%0d required=1/10/100100111/1",
               wr_en, wr_addr, wr_data, count);
    end
    @(posedge clk); #1;
    n_tests++;
    if (wr_en !== 1'b0 || wr_data !== 9'b10_01_00111 || wr_addr !== 8'h10) begin
      n_fail++;
      $display("FAIL strobe_one_cycle en=%b data=%b addr=%h required=0/100100111/10",
               wr_en, wr_data, wr_addr);
    end
    set_beat(oHALT, 3'd0, 5'd0);
    exp_q.push_back('{a: 8'h11, d: 9'b00_1001_000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (done !== 1'b1 || count !== 9'd2) begin
      n_fail++;
      $display("FAIL halt_after_addi done=%b cnt=%0d required=1/2", done, count);
    end
  endtask

  task automatic test_back_to_back;
    do_start(8'h10);
    n_tests++;
    if (done !== 1'b0 || count !== 9'd0) begin
      n_fail++;
      $display("FAIL restart_clear done=%b cnt=%0d required=0/0", done, count);
    end
    set_beat(oMOVER, 3'd3, 5'd0);
    exp_q.push_back('{a: 8'h10, d: 9'b00_0001_011});
    @(posedge clk); #1;
    set_beat(oBEQ, 3'd2, 5'd5);
    exp_q.push_back('{a: 8'h11, d: 9'b01_0_010_101});
    @(posedge clk); #1;
    set_beat(oHALT, 3'd0, 5'd0);
    exp_q.push_back('{a: 8'h12, d: 9'b00_1001_000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (done !== 1'b1 || count !== 9'd3 || in_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end done=%b cnt=%0d ready=%b busy=%b err=%b required=1/3/0/0/0",
               done, count, in_ready, busy, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_imm_range;
    do_start(8'h40);
    set_beat(oLSR, 3'd1, 5'b01000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (wr_en !== 1'b0 || err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0 || count !== 9'd0) begin
      n_fail++;
      $display("FAIL imm_range en=%b err=%b code=%b busy=%b cnt=%0d required=0/1/10/0/0",
               wr_en, err, err_code, busy, count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_op;
    do_start(8'h20);
    n_tests++;
    if (err !== 1'b0 || err_code !== 2'b00) begin
      n_fail++;
      $display("FAIL start_clears_err err=%b code=%b required=0/00", err, err_code);
    end
    set_beat(5'd31, 3'd0, 5'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (wr_en !== 1'b0 || err !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_op en=%b err=%b code=%b busy=%b required=0/1/01/0",
               wr_en, err, err_code, busy);
    end
    do_start(8'h20);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1 || count !== 9'd0) begin
      n_fail++;
      $display("FAIL restart_after_err err=%b busy=%b cnt=%0d required=0/1/0", err, busy, count);
    end
    set_beat(oADD, 3'd5, 5'd0);
    exp_q.push_back('{a: 8'h20, d: 9'b00_0000_101});
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Start while running must not move the pointer.
    do_start(8'h50);
    set_beat(oXOR, 3'd1, 5'd0);
    exp_q.push_back('{a: 8'h21, d: 9'b00_0101_001});
    @(posedge clk); #1;
    set_beat(oHALT, 3'd0, 5'd0);
    exp_q.push_back('{a: 8'h22, d: 9'b00_1001_000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (done !== 1'b1 || count !== 9'd3) begin
      n_fail++;
      $display("FAIL start_in_run_ignored done=%b cnt=%0d required=1/3", done, count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    do_start(8'hFE);
    set_beat(oADD, 3'd0, 5'd0);
    exp_q.push_back('{a: 8'hFE, d: 9'b00_0000_000});
    @(posedge clk); #1;
    set_beat(oSUB, 3'd0, 5'd3);
    exp_q.push_back('{a: 8'hFF, d: 9'b10_10_00011});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (err !== 1'b1 || err_code !== 2'b11 || count !== 9'd2 || in_ready !== 1'b0 || wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow err=%b code=%b cnt=%0d ready=%b en=%b required=1/11/2/0/1",
               err, err_code, count, in_ready, wr_en);
    end
    @(posedge clk); #1;
    do_start(8'hFF);
    set_beat(oHALT, 3'd2, 5'd0);
    exp_q.push_back('{a: 8'hFF, d: 9'b00_1001_010});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (done !== 1'b1 || err !== 1'b0 || count !== 9'd1) begin
      n_fail++;
      $display("FAIL halt_at_top done=%b err=%b cnt=%0d required=1/0/1", done, err, count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midload;
    do_start(8'h30);
    set_beat(oAND, 3'd4, 5'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_write en=%b required=1", wr_en);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({wr_en, busy, in_ready, done, err, err_code, count, wr_addr, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL async_reset actual=%b required=0",
               {wr_en, busy, in_ready, done, err, err_code, count, wr_addr, wr_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Idle after reset: a beat without Start must not be taken.
    set_beat(oADD, 3'd1, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (wr_en !== 1'b0 || in_ready !== 1'b0 || count !== 9'd0) begin
      n_fail++;
      $display("FAIL idle_ignores_beat en=%b ready=%b cnt=%0d required=0/0/0", wr_en, in_ready, count);
    end
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_back_to_back();
    test_imm_range();
    test_illegal_op();
    test_overflow();
    test_reset_midload();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
